// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg
//   Shared op encodings, controller state type and divider latency.
//   Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam logic [1:0] OP_DIV_W  = 2'b00;
    localparam logic [1:0] OP_MOD_W  = 2'b01;
    localparam logic [1:0] OP_DIV_WU = 2'b10;
    localparam logic [1:0] OP_MOD_WU = 2'b11;

    // Cycles from the first start-high cycle to the complete cycle, inclusive.
    localparam int DIV_LAT = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div.sv
// ============================================================================
// div
//   Iterative restoring 32-bit divider. Quotient is valid in the complete
//   cycle, the sign-corrected remainder one cycle later.
//   Rev 1.0
// ============================================================================
`default_nettype none

module div (
    input  logic        div_clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder,
    output logic        o_complete
);
    import div_pkg::*;

    localparam logic [5:0] c_CNT_LAST = 6'(DIV_LAT - 1);

    logic [5:0]  r_cnt;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic        r_negq;
    logic        r_negr;

    logic [31:0] w_x_abs;
    logic [31:0] w_y_abs;
    logic [32:0] w_pshift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_step_rem;

    assign w_x_abs    = (i_signed & i_x[31]) ? (32'd0 - i_x) : i_x;
    assign w_y_abs    = (i_signed & i_y[31]) ? (32'd0 - i_y) : i_y;
    assign w_pshift   = {r_rem, r_quo[31]};
    assign w_ge       = (w_pshift >= {1'b0, r_dvs});
    assign w_diff     = w_pshift[31:0] - r_dvs;
    assign w_step_rem = w_ge ? w_diff : w_pshift[31:0];

    // Dropping start at any point restarts the next run from the load step.
    always_ff @(posedge div_clk) begin
        if (reset || !i_start) begin
            r_cnt <= '0;
        end else if (r_cnt != 6'h3f) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    always_ff @(posedge div_clk) begin
        if (reset) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
        end else if (i_start) begin
            if (r_cnt == 6'd0) begin
                r_quo  <= w_x_abs;
                r_rem  <= '0;
                r_dvs  <= w_y_abs;
                r_negq <= i_signed & (i_x[31] ^ i_y[31]);
                r_negr <= i_signed & i_x[31];
            end else if (r_cnt <= 6'd32) begin
                r_rem <= w_step_rem;
                r_quo <= {r_quo[30:0], w_ge};
            end else if (r_cnt == c_CNT_LAST) begin
                r_rem <= r_negr ? (32'd0 - r_rem) : r_rem;
            end
        end
    end

    assign o_quotient  = r_negq ? (32'd0 - r_quo) : r_quo;
    assign o_remainder = r_rem;
    assign o_complete  = i_start & (r_cnt == c_CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// ============================================================================
// div_issue_ctrl
//   Issue/capture sequencer between EX and the iterative divider, with
//   flush and a runaway-run watchdog.
//   Rev 1.0
// ============================================================================
`default_nettype none

module div_issue_ctrl #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 40
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [1:0]       i_in_op,
    input  logic [31:0]      i_in_src1,
    input  logic [31:0]      i_in_src2,
    input  logic [TAG_W-1:0] i_in_tag,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_out_result,
    output logic [TAG_W-1:0] o_out_tag,
    output logic             o_busy,
    output logic             o_err
);
    import div_pkg::*;

    localparam int c_WD_W = $clog2(TIMEOUT + 1);

    div_state_e       r_state;
    logic [1:0]       r_op;
    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [TAG_W-1:0] r_tag;
    logic [c_WD_W-1:0] r_wdog;
    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_err;

    logic             w_accept;
    logic             w_div_start;
    logic             w_div_signed;
    logic             w_div_complete;
    logic             w_wd_expire;
    logic             w_sel_rem;
    logic [31:0]      w_quo;
    logic [31:0]      w_rem;

    assign o_in_ready   = ~i_flush & ~reset &
                          ((r_state == IDLE) | ((r_state == HOLD) & i_out_ready));
    assign w_accept     = i_in_valid & o_in_ready;
    // Start falls in the same cycle as reset or flush so the divider never sees a stale run.
    assign w_div_start  = (r_state == RUN) & ~i_flush & ~reset;
    assign w_div_signed = ~((r_op == OP_DIV_WU) | (r_op == OP_MOD_WU));
    assign w_sel_rem    = (r_op == OP_MOD_W) | (r_op == OP_MOD_WU);
    assign w_wd_expire  = (r_wdog == c_WD_W'(TIMEOUT - 1)) & ~w_div_complete;

    div u_div (
        .div_clk     (div_clk),
        .reset       (reset),
        .i_start     (w_div_start),
        .i_signed    (w_div_signed),
        .i_x         (r_src1),
        .i_y         (r_src2),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_complete  (w_div_complete)
    );

    always_ff @(posedge div_clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_op         <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_tag        <= '0;
            r_wdog       <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_err        <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_accept) begin
                r_op   <= i_in_op;
                r_src1 <= i_in_src1;
                r_src2 <= i_in_src2;
                r_tag  <= i_in_tag;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_wdog  <= '0;
                    end
                end
                RUN: begin
                    r_wdog <= r_wdog + 1'b1;
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else if (w_div_complete) begin
                        r_state <= CAPT;
                    end else if (w_wd_expire) begin
                        r_state <= IDLE;
                        r_err   <= 1'b1;
                    end
                end
                CAPT: begin
                    // Remainder is only final one cycle after complete, hence capture here.
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_out_result <= w_sel_rem ? w_rem : w_quo;
                        r_out_tag    <= r_tag;
                        r_out_valid  <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_flush) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_state <= RUN;
                            r_wdog  <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_out_valid  = r_out_valid;
    assign o_out_result = r_out_result;
    assign o_out_tag    = r_out_tag;
    assign o_busy       = (r_state != IDLE);
    assign o_err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ============================================================================
// tb_div_issue_ctrl
//   Directed and random checks of div_issue_ctrl against an arithmetic model.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_div_issue_ctrl;
    import div_pkg::*;

    localparam int TAG_W = 5;

    logic             div_clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_in_valid = 1'b0;
    logic             o_in_ready;
    logic [1:0]       i_in_op = 2'b00;
    logic [31:0]      i_in_src1 = '0;
    logic [31:0]      i_in_src2 = '0;
    logic [TAG_W-1:0] i_in_tag = '0;
    logic             i_flush = 1'b0;
    logic             o_out_valid;
    logic             i_out_ready = 1'b0;
    logic [31:0]      o_out_result;
    logic [TAG_W-1:0] o_out_tag;
    logic             o_busy;
    logic             o_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 div_clk = ~div_clk;

    div_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(40)) dut (
        .div_clk      (div_clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_op      (i_in_op),
        .i_in_src1    (i_in_src1),
        .i_in_src2    (i_in_src2),
        .i_in_tag     (i_in_tag),
        .i_flush      (i_flush),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_result (o_out_result),
        .o_out_tag    (o_out_tag),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge div_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Truncating division in 64-bit arithmetic, so no overflow corner needs special handling.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r;
        if (op[1]) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[0] ? r[31:0] : q[31:0];
    endfunction

    // Issues one request in the current cycle and leaves the bench in the first out_valid cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input logic hold_rdy, input string name);
        logic [31:0] exp;
        logic        bad;
        exp = ref_result(op, a, b);
        i_in_valid  = 1'b1;
        i_in_op     = op;
        i_in_src1   = a;
        i_in_src2   = b;
        i_in_tag    = tag;
        i_out_ready = 1'b1;
        #1;
        chk({name, "_accept"}, 32'(o_in_ready), 32'd1);
        tick();
        i_in_valid  = 1'b0;
        i_in_op     = 2'($urandom);
        i_in_src1   = $urandom;
        i_in_src2   = $urandom;
        i_in_tag    = TAG_W'($urandom);
        i_out_ready = hold_rdy;
        bad = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            #1;
            bad |= o_out_valid | o_in_ready | ~o_busy | o_err;
            tick();
        end
        chk({name, "_latency"}, 32'(bad), 32'd0);
        #1;
        chk({name, "_valid"}, 32'(o_out_valid), 32'd1);
        chk({name, "_result"}, o_out_result, exp);
        chk({name, "_tag"}, 32'(o_out_tag), 32'(tag));
    endtask

    initial begin
        logic        bad;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        // Reset
        i_in_valid = 1'b1;
        tick();
        tick();
        #1;
        chk("reset_in_ready", 32'(o_in_ready), 32'd0);
        tick();
        reset      = 1'b0;
        i_in_valid = 1'b0;
        #1;
        chk("reset_out_valid", 32'(o_out_valid), 32'd0);
        chk("reset_err", 32'(o_err), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_result", o_out_result, 32'd0);
        chk("reset_tag", 32'(o_out_tag), 32'd0);
        chk("reset_ready", 32'(o_in_ready), 32'd1);

        // Basic ops
        do_op(OP_DIV_W, 32'd7, 32'd2, 5'd3, 1'b1, "div7_2");
        chk("div7_2_const", o_out_result, 32'h0000_0003);
        chk("div7_2_ready_again", 32'(o_in_ready), 32'd1);
        tick();
        #1;
        chk("div7_2_consumed", 32'(o_out_valid), 32'd0);
        do_op(OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, "modw_neg");
        chk("modw_neg_const", o_out_result, 32'hFFFF_FFFF);
        tick();
        do_op(OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, "divw_neg");
        chk("divw_neg_const", o_out_result, 32'hFFFF_FFFD);
        tick();
        do_op(OP_DIV_WU, 32'hFFFF_FFFE, 32'd2, 5'd6, 1'b1, "divwu");
        chk("divwu_const", o_out_result, 32'h7FFF_FFFF);
        tick();
        do_op(OP_MOD_WU, 32'hFFFF_FFFF, 32'd16, 5'd7, 1'b1, "modwu");
        chk("modwu_const", o_out_result, 32'h0000_000F);
        tick();

        // Hold stability, then back-to-back accept in the handshake cycle
        do_op(OP_DIV_W, 32'd50, 32'd5, 5'd9, 1'b0, "hold");
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            #1;
            bad |= ~o_out_valid | (o_out_result != 32'd10) | (o_out_tag != 5'd9) | o_in_ready;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        do_op(OP_DIV_W, 32'd100, 32'd7, 5'd12, 1'b1, "b2b");
        chk("b2b_const", o_out_result, 32'h0000_000E);
        tick();

        // Flush in RUN cycle 10
        i_in_valid = 1'b1; i_in_op = OP_DIV_W; i_in_src1 = 32'd77; i_in_src2 = 32'd5; i_in_tag = 5'd1;
        tick();
        i_in_valid = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk("flush_run_idle", 32'(o_busy), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            bad |= o_out_valid | o_err | o_busy;
            tick();
        end
        chk("flush_run_no_result", 32'(bad), 32'd0);
        do_op(OP_DIV_W, 32'd9, 32'd3, 5'd2, 1'b1, "after_flush");
        tick();

        // Flush coinciding with complete
        i_in_valid = 1'b1; i_in_op = OP_MOD_W; i_in_src1 = 32'd77; i_in_src2 = 32'd5; i_in_tag = 5'd8;
        tick();
        i_in_valid = 1'b0;
        for (int c = 1; c < 34; c++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        chk("flush_cmpl_idle", 32'(o_busy), 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            bad |= o_out_valid | o_err;
            tick();
        end
        chk("flush_cmpl_no_result", 32'(bad), 32'd0);

        // Flush in HOLD with out_ready high and a request presented
        do_op(OP_DIV_WU, 32'd1000, 32'd10, 5'd11, 1'b1, "pre_hflush");
        i_flush    = 1'b1;
        i_in_valid = 1'b1;
        #1;
        chk("hflush_not_ready", 32'(o_in_ready), 32'd0);
        tick();
        i_flush    = 1'b0;
        i_in_valid = 1'b0;
        #1;
        chk("hflush_valid_drop", 32'(o_out_valid), 32'd0);
        chk("hflush_not_accepted", 32'(o_busy), 32'd0);
        chk("hflush_no_err", 32'(o_err), 32'd0);
        tick();

        // Watchdog with divider complete suppressed
        force dut.w_div_complete = 1'b0;
        i_in_valid = 1'b1; i_in_op = OP_DIV_W; i_in_src1 = 32'd20; i_in_src2 = 32'd4; i_in_tag = 5'd15;
        #1;
        chk("wd_accept", 32'(o_in_ready), 32'd1);
        tick();
        i_in_valid = 1'b0;
        bad = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            bad |= o_err | ~o_busy | o_out_valid;
            tick();
        end
        chk("wd_quiet_40", 32'(bad), 32'd0);
        #1;
        chk("wd_err", 32'(o_err), 32'd1);
        chk("wd_idle", 32'(o_busy), 32'd0);
        tick();
        #1;
        chk("wd_err_pulse", 32'(o_err), 32'd0);
        release dut.w_div_complete;
        do_op(OP_DIV_W, 32'd20, 32'd4, 5'd16, 1'b1, "after_wd");
        tick();

        // Random ops against the model, some issued back-to-back
        for (int i = 0; i < 10; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 1) ? 32'($urandom_range(1, 100)) : $urandom;
            if (rb == 32'd0) rb = 32'd1;
            do_op(rop, ra, rb, TAG_W'($urandom), 1'b1, "rand");
            if (i % 3 != 0) tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative 32-bit divider.
- Accepts DIV.W / MOD.W / DIV.WU / MOD.WU requests over a valid/ready handshake and latches the operands.
- Drives the divider and holds its operands stable for the whole run, then captures the quotient and remainder.
- Presents the selected result with a tag until the consumer takes it. Supports pipeline flush and a watchdog on runaway runs.

Parameters:
TAG_W, 5, width of the opaque request tag (e.g. destination register index)
TIMEOUT, 40, maximum RUN cycles without divider complete before the error abort

Ports:
div_clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_op  in  2  00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU
in_src1  in  32  dividend
in_src2  in  32  divisor
in_tag  in  TAG_W  tag returned with the result
flush  in  1  cancel any in-flight or held operation
out_valid  out  1  result valid
out_ready  in  1  consumer takes result when out_valid & out_ready
out_result  out  32  quotient (op[0]=0) or remainder (op[0]=1)
out_tag  out  TAG_W  tag of the held result
busy  out  1  state != IDLE
err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE, out_valid=0, err=0, busy=0, out_result=0, out_tag=0, divider start low, watchdog counter=0.
  - Reset mid-run drops the divider start the same cycle.
  - The divider resets its own counter.
- States:
  - IDLE: divider start=0. Accept when in_valid & in_ready, then go to RUN.
  - RUN: divider start=1, signed = ~op[1], x/y from the operand latches.
  - CAPT: divider start=0. Latch divider quotient/remainder, then go to HOLD.
  - HOLD: out_valid=1.
- RUN exit: on divider complete go to CAPT. The remainder settles one cycle after complete, so both values are captured in CAPT, never in the complete cycle.
- HOLD exits:
  - On out_valid & out_ready go to IDLE, or directly to RUN if a new request fires in the same cycle.
  - Without a handshake, out_result and out_tag stay stable.
- in_ready = ~flush & ~reset & (state==IDLE | (state==HOLD & out_ready)).
- Operands, op and tag are latched only on accept and are constant through RUN/CAPT/HOLD.
- Divider start must be low for at least one cycle between runs. IDLE, CAPT and HOLD guarantee this; a new run never starts in the cycle following complete.
- Latency: accept cycle = 0; RUN cycles 1..34; complete in cycle 34; CAPT cycle 35; out_valid high from cycle 36. Throughput is one op per 36 cycles with out_ready held high.
- Result select:
  - op[0]=0 gives the quotient, op[0]=1 the remainder, as signed or unsigned per op[1].
  - Divide-by-zero returns whatever the divider produces; no special case and no trap.
- Flush (priority over everything except reset):
  - In RUN or CAPT: go to IDLE next cycle, start low immediately, no result, no err.
  - In HOLD: drop out_valid next cycle; the result is discarded even if out_ready is high the same cycle.
  - Flush coinciding with complete: discard.
  - A request presented with flush is not accepted.
- Watchdog:
  - Counts RUN cycles and clears on RUN entry.
  - Reaching TIMEOUT without complete: err=1 for one cycle, go to IDLE, start low.
- busy=1 in RUN, CAPT and HOLD.

Decomposition:
- Package div_pkg: op encoding constants (OP_DIV_W, OP_MOD_W, OP_DIV_WU, OP_MOD_WU), state enum (IDLE, RUN, CAPT, HOLD), DIV_LAT=34 constant.
- One sub-module: the existing iterative divider `div`, instantiated inside with div_clk/reset shared.
- The watchdog stays inline.

Test Plan:
- Reset, then DIV.W 7/2, tag 3, out_ready=1 → in_ready=0 cycles 1..35; out_valid at cycle 36 with result 0x00000003, tag 3; in_ready=1 again.
- MOD.W -7 % 2 and DIV.W -7 / 2 → 0xFFFFFFFF and 0xFFFFFFFD; DIV.WU 0xFFFFFFFE / 2 → 0x7FFFFFFF; MOD.WU 0xFFFFFFFF % 16 → 0x0000000F.
- out_ready=0 for 10 cycles after out_valid → result and tag stable. Then out_ready=1 with a new request (DIV.W 100/7) in the same cycle → accepted, next result 0x0000000E.
- flush in RUN cycle 10 → IDLE next cycle, no out_valid. Next request 9/3 → 0x00000003 with the full 36-cycle latency (divider restarts cleanly).
- flush in the complete cycle, and separately in HOLD with out_ready=1 → no result delivered; no err.
- Divider complete forced low (bind/force) → err pulse after 40 RUN cycles, return to IDLE, busy=0, next request completes normally.
